// File: rtl/mult_arbiter_if.sv
// Bundle of the request, response and multiplier-core signals of mult_arbiter.
// The slave modport is the arbiter side. The master modport is the
// environment side: the clients, the response consumer and the multiplier core.
interface mult_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_mp;
    logic [NREQ*N-1:0] req_mc;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_p;
    logic              rsp_err;
    logic              rsp_ready;
    logic [N-1:0]      mul_mp;
    logic [N-1:0]      mul_mc;
    logic              mul_start;
    logic              mul_done;
    logic [2*N-1:0]    mul_p;

    modport slave (
        input  req_valid, req_mp, req_mc, rsp_ready, mul_done, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_mp, mul_mc, mul_start
    );

    modport master (
        output req_valid, req_mp, req_mc, rsp_ready, mul_done, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_mp, mul_mc, mul_start
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared serial multiplier.
// It grants one requester at a time, starts the core, waits for done, and
// returns the tagged product.
// Optional macro ARB_TIMEOUT_EN: bounds the wait for mul_done to TIMEOUT
// cycles. On expiry the arbiter returns rsp_err=1 and rsp_p=0.
module mult_arbiter #(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          resetn,
    mult_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, START, CLR, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NREQ-1:0]  ready_d;
    logic             start_d;
    logic [N-1:0]     mp_d, mc_d;
    logic             rsp_valid_d, rsp_err_d;
    logic [IDW-1:0]   rsp_id_d;
    logic [2*N-1:0]   rsp_p_d;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    // Fold an index in [0, 2*NREQ) back into [0, NREQ).
    function automatic int wrap(input int v);
        return (v >= NREQ) ? v - NREQ : v;
    endfunction

    // Find the first valid requester, searching upward from the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[wrap(int'(ptr_q) + k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(wrap(int'(ptr_q) + k));
            end
        end
    end

    // Next-state and next-output logic. Every output is registered below.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ready_d     = '0;
        start_d     = 1'b0;
        mp_d        = bus.mul_mp;
        mc_d        = bus.mul_mc;
        rsp_valid_d = bus.rsp_valid;
        rsp_err_d   = bus.rsp_err;
        rsp_id_d    = bus.rsp_id;
        rsp_p_d     = bus.rsp_p;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    ready_d[gnt_idx] = 1'b1;
                    mp_d             = bus.req_mp[gnt_idx*N +: N];
                    mc_d             = bus.req_mc[gnt_idx*N +: N];
                    id_d             = gnt_idx;
                    ptr_d            = IDW'(wrap(int'(gnt_idx) + 1));
                    state_d          = START;
                end
            end
            START: begin
                start_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = CLR;
            end
            CLR: begin
                // A done still high from the previous job is stale; wait for the core to clear it.
                if (!bus.mul_done) state_d = BUSY;
            end
            BUSY: begin
                if (bus.mul_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_p_d     = bus.mul_p;
                    rsp_id_d    = id_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        // A normal completion in the same cycle takes priority over the timeout.
        if ((state_q == CLR || state_q == BUSY) && state_d != RESP) begin
            if (cnt_q == CW'(TIMEOUT)) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_p_d     = '0;
                rsp_id_d    = id_q;
                state_d     = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the reset branch covers every register; the design holds no memory arrays.
        if (!resetn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            id_q          <= '0;
            bus.req_ready <= '0;
            bus.mul_start <= 1'b0;
            bus.mul_mp    <= '0;
            bus.mul_mc    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_p     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            bus.req_ready <= ready_d;
            bus.mul_start <= start_d;
            bus.mul_mp    <= mp_d;
            bus.mul_mc    <= mc_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_err   <= rsp_err_d;
            bus.rsp_id    <= rsp_id_d;
            bus.rsp_p     <= rsp_p_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter.
// It models the serial multiplier core behaviourally and checks grant order and
// products against a round-robin reference model.
// The timeout scenario is built only when ARB_TIMEOUT_EN is defined.
module tb_mult_arbiter;
    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 100;
    localparam int LAT     = 2*N + 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [2*N-1:0] p;
        logic           err;
        int             cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic stuck = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus();

    mult_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int hs_cyc = 0;
    int start_run = 0;
    int max_start_run = 0;
    int model_ptr = 0;
    logic [NREQ-1:0] grant_q[$];
    int              grant_cyc[$];
    rsp_t            rsp_q[$];

    // Behavioural multiplier core. On start it clears done. LAT cycles later
    // it raises done with the product. While busy, mul_p carries noise.
    logic [N-1:0] ca, cb;
    int busy_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mul_done <= 1'b0;
            bus.mul_p    <= '0;
            busy_cnt     <= 0;
        end else if (bus.mul_start) begin
            bus.mul_done <= 1'b0;
            ca           <= bus.mul_mp;
            cb           <= bus.mul_mc;
            busy_cnt     <= LAT;
        end else if (busy_cnt > 0) begin
            busy_cnt  <= busy_cnt - 1;
            bus.mul_p <= {$urandom, $urandom};
            if (busy_cnt == 1 && !stuck) begin
                bus.mul_done <= 1'b1;
                bus.mul_p    <= {{N{1'b0}}, ca} * {{N{1'b0}}, cb};
            end
        end
    end

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [2*N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    // Advance one cycle and record handshakes. Granted requesters drop req_valid.
    task automatic step();
        logic v, r;
        rsp_t e;
        v = bus.rsp_valid; r = bus.rsp_ready;
        e.id = bus.rsp_id; e.p = bus.rsp_p; e.err = bus.rsp_err; e.cyc = rise_cyc;
        @(negedge clk);
        cyc++;
        if (v && r) begin rsp_q.push_back(e); hs_cyc = cyc; end
        if (bus.rsp_valid && !v) rise_cyc = cyc;
        if (bus.mul_start) start_run++; else start_run = 0;
        if (start_run > max_start_run) max_start_run = start_run;
        if (bus.req_ready != '0) begin
            grant_q.push_back(bus.req_ready);
            grant_cyc.push_back(cyc);
            bus.req_valid = bus.req_valid & ~bus.req_ready;
        end
    endtask

    task automatic post(input int i, input logic [N-1:0] mp, input logic [N-1:0] mc);
        bus.req_mp[i*N +: N] = mp;
        bus.req_mc[i*N +: N] = mc;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic wait_rsps(input int n, input int budget, input bit rand_ready, output bit ok);
        int k = 0;
        while (rsp_q.size() < n && k < budget) begin
            if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        bus.rsp_ready = 1'b1;
        ok = (rsp_q.size() >= n);
    endtask

    task automatic wait_grants(input int n, input int budget, output bit ok);
        int k = 0;
        while (grant_q.size() < n && k < budget) begin step(); k++; end
        ok = (grant_q.size() >= n);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        grant_q.delete(); grant_cyc.delete(); rsp_q.delete();
        model_ptr = 0; max_start_run = 0; start_run = 0;
        step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.req_ready, bus.mul_start} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req_ready=%b mul_start=%b, required 0", bus.req_ready, bus.mul_start);
        end
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_p} !== '0) begin
            tests_failed++;
            $display("FAIL reset_rsp: valid=%b err=%b id=%0d p=%h, required all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_p);
        end
        tests_run++;
        if ({bus.mul_mp, bus.mul_mc} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ops: mp=%h mc=%h, required 0", bus.mul_mp, bus.mul_mc);
        end
        apply_reset();
    endtask

    task automatic test_single();
        bit ok;
        post(0, 3, 5);
        wait_rsps(1, LAT + 40, 1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL single_timeout: got %0d responses, required 1", rsp_q.size());
        end else begin
            tests_run++;
            if (grant_q.size() != 1 || grant_q[0] !== 4'b0001) begin
                tests_failed++;
                $display("FAIL single_grant: got %0d grants first=%b, required 1 grant 0001",
                         grant_q.size(), grant_q[0]);
            end
            tests_run++;
            if (rsp_q[0].id !== 0 || rsp_q[0].p !== 64'd15 || rsp_q[0].err !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_rsp: id=%0d p=%0d err=%b, required id=0 p=15 err=0",
                         rsp_q[0].id, rsp_q[0].p, rsp_q[0].err);
            end
            tests_run++;
            if (rsp_q[0].cyc - grant_cyc[0] < LAT + 2 || rsp_q[0].cyc - grant_cyc[0] > LAT + 5) begin
                tests_failed++;
                $display("FAIL single_latency: got %0d cycles, required %0d..%0d",
                         rsp_q[0].cyc - grant_cyc[0], LAT + 2, LAT + 5);
            end
            tests_run++;
            if (max_start_run != 1) begin
                tests_failed++;
                $display("FAIL single_start_pulse: got %0d cycles, required 1", max_start_run);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) post(i, N'(i + 1), 2);
        wait_grants(1, 10, ok);
        post(0, 1, 2);
        wait_rsps(5, 5*(LAT + 20), 1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rr_timeout: got %0d responses, required 5", rsp_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (rsp_q[k].id !== IDW'(exp_id[k]) || rsp_q[k].p !== 64'(2*(exp_id[k] + 1))) begin
                    tests_failed++;
                    $display("FAIL rr_order[%0d]: id=%0d p=%0d, required id=%0d p=%0d",
                             k, rsp_q[k].id, rsp_q[k].p, exp_id[k], 2*(exp_id[k] + 1));
                end
            end
        end
        repeat (2) step();
    endtask

    task automatic test_wrap();
        bit ok;
        int base;
        post(3, 1, 1);
        wait_rsps(rsp_q.size() + 1, LAT + 40, 1'b0, ok);
        repeat (2) step();
        base = grant_q.size();
        post(0, 4, 4);
        post(2, 6, 6);
        wait_rsps(rsp_q.size() + 2, 2*(LAT + 20), 1'b0, ok);
        tests_run++;
        if (!ok || grant_q.size() != base + 2) begin
            tests_failed++;
            $display("FAIL wrap_timeout: got %0d grants, required %0d", grant_q.size(), base + 2);
        end else begin
            tests_run++;
            if (grant_q[base-1] !== 4'b1000 || grant_q[base] !== 4'b0001 || grant_q[base+1] !== 4'b0100) begin
                tests_failed++;
                $display("FAIL wrap_order: got %b,%b,%b, required 1000,0001,0100",
                         grant_q[base-1], grant_q[base], grant_q[base+1]);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0, r0, k;
        logic [N-1:0] a, b;
        logic [2*N-1:0] p0;
        logic [IDW-1:0] id0;
        a = $urandom; b = $urandom;
        bus.rsp_ready = 1'b0;
        post(1, a, b);
        k = 0;
        while (!bus.rsp_valid && k < LAT + 40) begin step(); k++; end
        tests_run++;
        if (!bus.rsp_valid) begin
            tests_failed++;
            $display("FAIL bp_timeout: rsp_valid=0 after %0d cycles, required 1", k);
        end
        post(2, 9, 11);
        p0 = bus.rsp_p; id0 = bus.rsp_id;
        n0 = grant_q.size(); r0 = rsp_q.size();
        tests_run++;
        if (p0 !== mul(a, b) || id0 !== 1) begin
            tests_failed++;
            $display("FAIL bp_value: id=%0d p=%h, required id=1 p=%h", id0, p0, mul(a, b));
        end
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== p0 || bus.rsp_id !== id0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d p=%h, required 1 %0d %h",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_p, id0, p0);
            end
        end
        tests_run++;
        if (grant_q.size() != n0) begin
            tests_failed++;
            $display("FAIL bp_no_grant: got %0d grants, required %0d", grant_q.size(), n0);
        end
        bus.rsp_ready = 1'b1;
        wait_grants(n0 + 1, 10, ok);
        tests_run++;
        if (!ok || rsp_q.size() != r0 + 1) begin
            tests_failed++;
            $display("FAIL bp_release: grants=%0d rsps=%0d, required %0d %0d",
                     grant_q.size(), rsp_q.size(), n0 + 1, r0 + 1);
        end else begin
            tests_run++;
            if (grant_cyc[n0] - hs_cyc != 1 || grant_q[n0] !== 4'b0100) begin
                tests_failed++;
                $display("FAIL bp_next_grant: gap=%0d grant=%b, required gap=1 grant=0100",
                         grant_cyc[n0] - hs_cyc, grant_q[n0]);
            end
        end
        wait_rsps(r0 + 2, LAT + 40, 1'b0, ok);
        tests_run++;
        if (!ok || rsp_q[r0+1].p !== 64'd99 || rsp_q[r0+1].id !== 2) begin
            tests_failed++;
            $display("FAIL bp_second: ok=%b, required id=2 p=99", ok);
        end
        repeat (2) step();
    endtask

    task automatic test_max_operands();
        bit ok;
        int i, r0;
        i = $urandom_range(0, NREQ - 1);
        r0 = rsp_q.size();
        post(i, '1, '1);
        wait_rsps(r0 + 1, LAT + 40, 1'b0, ok);
        tests_run++;
        if (!ok || rsp_q[r0].p !== 64'hFFFFFFFE00000001 || rsp_q[r0].id !== IDW'(i)) begin
            tests_failed++;
            $display("FAIL max_operands: ok=%b, required id=%0d p=fffffffe00000001", ok, i);
        end
        repeat (2) step();
    endtask

    task automatic test_random();
        bit ok;
        logic [N-1:0] mp_a[NREQ], mc_a[NREQ];
        logic [NREQ-1:0] mask, left;
        int exp_ids[$];
        int base, g;
        apply_reset();
        for (int round = 0; round < 6; round++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            base = rsp_q.size();
            exp_ids.delete();
            left = mask;
            while (left != '0) begin
                g = rr_pick(model_ptr, left);
                exp_ids.push_back(g);
                left[g] = 1'b0;
                model_ptr = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                mp_a[i] = $urandom; mc_a[i] = $urandom;
                if (mask[i]) post(i, mp_a[i], mc_a[i]);
            end
            wait_rsps(base + exp_ids.size(), exp_ids.size()*(LAT + 40) + 50, 1'b1, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL rand_timeout[%0d]: got %0d responses, required %0d",
                         round, rsp_q.size() - base, exp_ids.size());
            end else begin
                foreach (exp_ids[k]) begin
                    tests_run++;
                    if (rsp_q[base+k].id !== IDW'(exp_ids[k]) ||
                        rsp_q[base+k].p !== mul(mp_a[exp_ids[k]], mc_a[exp_ids[k]])) begin
                        tests_failed++;
                        $display("FAIL rand[%0d.%0d]: id=%0d p=%h, required id=%0d p=%h",
                                 round, k, rsp_q[base+k].id, rsp_q[base+k].p, exp_ids[k],
                                 mul(mp_a[exp_ids[k]], mc_a[exp_ids[k]]));
                    end
                end
            end
            repeat (2) step();
        end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        post(1, 7, 9);
        wait_grants(grant_q.size() + 1, 10, ok);
        repeat (20) step();
        resetn = 1'b0;
        bus.req_valid = '0;
        #1;
        tests_run++;
        if ({bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.rsp_id,
             bus.rsp_p, bus.mul_mp, bus.mul_mc} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: rsp_valid=%b mp=%h mc=%h p=%h, required all 0",
                     bus.rsp_valid, bus.mul_mp, bus.mul_mc, bus.rsp_p);
        end
        @(negedge clk);
        resetn = 1'b1;
        rsp_q.delete();
        repeat (LAT + 20) step();
        tests_run++;
        if (rsp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_rsp: got %0d responses valid=%b, required 0", rsp_q.size(), bus.rsp_valid);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        apply_reset();
        stuck = 1'b1;
        post(2, 5, 5);
        wait_rsps(1, TIMEOUT + LAT + 50, 1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL timeout_none: got 0 responses, required 1");
        end else begin
            tests_run++;
            if (rsp_q[0].err !== 1'b1 || rsp_q[0].p !== '0 || rsp_q[0].id !== 2) begin
                tests_failed++;
                $display("FAIL timeout_rsp: err=%b p=%h id=%0d, required err=1 p=0 id=2",
                         rsp_q[0].err, rsp_q[0].p, rsp_q[0].id);
            end
            tests_run++;
            if (rsp_q[0].cyc - grant_cyc[0] < TIMEOUT + 1 || rsp_q[0].cyc - grant_cyc[0] > TIMEOUT + 4) begin
                tests_failed++;
                $display("FAIL timeout_latency: got %0d, required %0d..%0d",
                         rsp_q[0].cyc - grant_cyc[0], TIMEOUT + 1, TIMEOUT + 4);
            end
        end
        stuck = 1'b0;
        repeat (2) step();
        post(0, 6, 7);
        wait_rsps(2, LAT + 40, 1'b0, ok);
        tests_run++;
        if (!ok || rsp_q[1].err !== 1'b0 || rsp_q[1].p !== 64'd42) begin
            tests_failed++;
            $display("FAIL timeout_recover: ok=%b, required err=0 p=42", ok);
        end
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.req_mp    = '0;
        bus.req_mc    = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_max_operands();
        test_random();
        test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
